// File: rtl/llc_req_tracker_pkg.sv
// Shared types for the LLC request tracker: entry state encoding, entry record,
// response-kind constants and the set-field helper.
package llc_req_tracker_pkg;

  localparam int N_ENTRIES   = 4;
  localparam int LINE_ADDR_W = 26;
  localparam int SET_W       = 8;
  localparam int REQ_ID_W    = 4;
  localparam int INVACK_W    = 4;
  localparam int IDX_W       = $clog2(N_ENTRIES);
  localparam int BUSY_W      = IDX_W + 1;

  typedef enum logic [1:0] {
    TRK_IDLE = 2'd0,
    TRK_WAIT = 2'd1,
    TRK_DONE = 2'd2
  } trk_state_e;

  typedef struct packed {
    trk_state_e               state;
    logic [LINE_ADDR_W-1:0]   line_addr;
    logic [REQ_ID_W-1:0]      req_id;
    logic                     is_getm;
    logic [INVACK_W-1:0]      cnt;
    logic                     need_data;
  } llc_trk_entry_t;

  localparam logic RSP_INVACK = 1'b0;
  localparam logic RSP_DATA   = 1'b1;

  function automatic logic [SET_W-1:0] set_of(input logic [LINE_ADDR_W-1:0] addr);
    return addr[SET_W-1:0];
  endfunction

endpackage

// File: rtl/llc_req_tracker_if.sv
// Alloc / response / completion bundle between the LLC pipeline and the tracker.
interface llc_req_tracker_if;
  import llc_req_tracker_pkg::*;

  // alloc and done transfer on a cycle where valid && ready; valid never waits on ready.
  // rsp has no ready: a response is consumed in the cycle rsp_valid is high.
  logic                         alloc_valid;
  logic                         alloc_ready;
  logic [LINE_ADDR_W-1:0]       alloc_line_addr;
  logic [REQ_ID_W-1:0]          alloc_req_id;
  logic                         alloc_is_getm;
  logic [INVACK_W-1:0]          alloc_invack_cnt;
  logic                         alloc_need_data;
  logic                         alloc_conflict;
  logic [IDX_W-1:0]             alloc_idx;
  logic                         rsp_valid;
  logic [LINE_ADDR_W-1:0]       rsp_line_addr;
  logic                         rsp_is_data;
  logic                         rsp_err;
  logic                         done_valid;
  logic                         done_ready;
  logic [LINE_ADDR_W-1:0]       done_line_addr;
  logic [REQ_ID_W-1:0]          done_req_id;
  logic                         done_is_getm;
  logic [BUSY_W-1:0]            busy_count;
  trk_state_e [N_ENTRIES-1:0]   dbg_state;

  modport slave (
    input  alloc_valid, alloc_line_addr, alloc_req_id, alloc_is_getm,
           alloc_invack_cnt, alloc_need_data, rsp_valid, rsp_line_addr,
           rsp_is_data, done_ready,
    output alloc_ready, alloc_conflict, alloc_idx, rsp_err, done_valid,
           done_line_addr, done_req_id, done_is_getm, busy_count, dbg_state
  );

  modport master (
    output alloc_valid, alloc_line_addr, alloc_req_id, alloc_is_getm,
           alloc_invack_cnt, alloc_need_data, rsp_valid, rsp_line_addr,
           rsp_is_data, done_ready,
    input  alloc_ready, alloc_conflict, alloc_idx, rsp_err, done_valid,
           done_line_addr, done_req_id, done_is_getm, busy_count, dbg_state
  );

endinterface

// File: rtl/llc_req_tracker_prio_enc.sv
// Lowest-index-set priority encoder; idx is 0 when nothing is requested.
module llc_trk_prio_enc #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  output logic         found,
  output logic [W-1:0] idx
);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        idx   = W'(i);
      end
    end
  end

endmodule

// File: rtl/llc_req_tracker.sv
// LLC-side tracker of in-flight GetS/GetM transactions: counts invacks and owner
// data per entry, holds one transaction per set, and hands completions to the pipeline.
module llc_req_tracker
  import llc_req_tracker_pkg::*;
(
  input logic          clk,
  input logic          rst,
  llc_req_tracker_if.slave bus
);

  llc_trk_entry_t        ent [N_ENTRIES];
  logic [N_ENTRIES-1:0]  free_vec, done_vec;
  logic                  free_found, done_found, conflict;
  logic [IDX_W-1:0]      free_idx, done_idx, sel_idx, rsp_idx;
  logic                  alloc_ready_w, alloc_fire, done_fire;
  logic                  rsp_hit, rsp_ok;
  logic [INVACK_W-1:0]   upd_cnt;
  logic                  upd_need;
  logic                  hold_q;
  logic [IDX_W-1:0]      hold_idx_q;
  logic [BUSY_W-1:0]     busy_q;
  logic                  err_q;

  always_comb begin
    free_vec = '0;
    done_vec = '0;
    conflict = 1'b0;
    rsp_hit  = 1'b0;
    rsp_idx  = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      free_vec[i] = (ent[i].state == TRK_IDLE);
      done_vec[i] = (ent[i].state == TRK_DONE);
      if (ent[i].state != TRK_IDLE) begin
        if (set_of(ent[i].line_addr) == set_of(bus.alloc_line_addr)) conflict = 1'b1;
        if (ent[i].line_addr == bus.rsp_line_addr) begin
          rsp_hit = 1'b1;
          rsp_idx = IDX_W'(i);
        end
      end
    end
  end

  llc_trk_prio_enc #(.N(N_ENTRIES)) u_free_sel (.req(free_vec), .found(free_found), .idx(free_idx));
  llc_trk_prio_enc #(.N(N_ENTRIES)) u_done_sel (.req(done_vec), .found(done_found), .idx(done_idx));

  // A presented completion is pinned until taken, even if a lower entry finishes meanwhile.
  assign sel_idx       = hold_q ? hold_idx_q : done_idx;
  assign alloc_ready_w = free_found && !conflict;
  assign alloc_fire    = bus.alloc_valid && alloc_ready_w;
  assign done_fire     = done_found && bus.done_ready;

  // At most one non-IDLE entry can hold a given line, so the match is unique.
  assign rsp_ok   = rsp_hit && (ent[rsp_idx].state == TRK_WAIT) &&
                    ((bus.rsp_is_data == RSP_INVACK) ? (ent[rsp_idx].cnt != '0)
                                                     : ent[rsp_idx].need_data);
  assign upd_cnt  = (bus.rsp_is_data == RSP_INVACK) ? ent[rsp_idx].cnt - INVACK_W'(1)
                                                    : ent[rsp_idx].cnt;
  assign upd_need = (bus.rsp_is_data == RSP_INVACK) ? ent[rsp_idx].need_data : 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_ENTRIES; i++) ent[i] <= '0;
      hold_q     <= 1'b0;
      hold_idx_q <= '0;
      busy_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      err_q      <= bus.rsp_valid && !rsp_ok;
      busy_q     <= busy_q + BUSY_W'(alloc_fire) - BUSY_W'(done_fire);
      hold_q     <= done_found && !bus.done_ready;
      hold_idx_q <= sel_idx;
      for (int i = 0; i < N_ENTRIES; i++) begin
        case (ent[i].state)
          TRK_IDLE: begin
            if (alloc_fire && free_idx == IDX_W'(i)) begin
              ent[i].line_addr <= bus.alloc_line_addr;
              ent[i].req_id    <= bus.alloc_req_id;
              ent[i].is_getm   <= bus.alloc_is_getm;
              ent[i].cnt       <= bus.alloc_invack_cnt;
              ent[i].need_data <= bus.alloc_need_data;
              ent[i].state     <= (bus.alloc_invack_cnt == '0 && !bus.alloc_need_data)
                                  ? TRK_DONE : TRK_WAIT;
            end
          end
          TRK_WAIT: begin
            if (bus.rsp_valid && rsp_ok && rsp_idx == IDX_W'(i)) begin
              ent[i].cnt       <= upd_cnt;
              ent[i].need_data <= upd_need;
              if (upd_cnt == '0 && !upd_need) ent[i].state <= TRK_DONE;
            end
          end
          TRK_DONE: begin
            if (done_fire && sel_idx == IDX_W'(i)) ent[i] <= '0;
          end
          default: ent[i] <= '0;
        endcase
      end
    end
  end

  assign bus.alloc_ready    = alloc_ready_w;
  assign bus.alloc_conflict = conflict;
  assign bus.alloc_idx      = free_idx;
  assign bus.rsp_err        = err_q;
  assign bus.done_valid     = done_found;
  assign bus.done_line_addr = ent[sel_idx].line_addr;
  assign bus.done_req_id    = ent[sel_idx].req_id;
  assign bus.done_is_getm   = ent[sel_idx].is_getm;
  assign bus.busy_count     = busy_q;

  always_comb begin
    for (int i = 0; i < N_ENTRIES; i++) bus.dbg_state[i] = ent[i].state;
  end

endmodule

// File: tb/tb_llc_req_tracker.sv
// Bench for llc_req_tracker: directed vector table, hand sequences for multi-cycle
// corners, then random traffic checked against a transaction-level model.
module tb_llc_req_tracker;
  import llc_req_tracker_pkg::*;

  logic clk = 1'b0;
  logic rst;
  llc_req_tracker_if bus ();

  llc_req_tracker dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    bit          av;
    logic [25:0] aa;
    logic [3:0]  aid;
    bit          ag;
    logic [3:0]  ac;
    bit          an;
    bit          rv;
    logic [25:0] ra;
    bit          rd;
    bit          dr;
  } stim_t;

  typedef struct {
    stim_t       s;
    bit          rdy;
    bit          conf;
    int          idx;
    bit          dv;
    logic [25:0] da;
    bit          dg;
    int          busy;
    bit          err;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Sampled DUT outputs: comb ones before the edge, registered ones after it.
  bit s_ready, s_conf, s_dv, s_dg, s_err;
  int s_idx, s_busy, s_did;
  logic [25:0] s_da;

  // Reference model: a table of outstanding transactions by slot.
  bit          m_used [N_ENTRIES];
  logic [25:0] m_addr [N_ENTRIES];
  int          m_id   [N_ENTRIES];
  bit          m_getm [N_ENTRIES];
  int          m_cnt  [N_ENTRIES];
  bit          m_need [N_ENTRIES];
  bit          m_hold;
  int          m_hold_idx;
  bit          m_err;
  int          m_nbusy;
  bit p_ready, p_conf, p_dv;
  int p_free, p_sel;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_fin(input int i);
    return m_used[i] && m_cnt[i] == 0 && !m_need[i];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N_ENTRIES; i++) begin
      m_used[i] = 0; m_addr[i] = '0; m_id[i] = 0; m_getm[i] = 0; m_cnt[i] = 0; m_need[i] = 0;
    end
    m_hold = 0; m_hold_idx = 0; m_err = 0; m_nbusy = 0;
  endtask

  task automatic model_predict(input stim_t s);
    bit has_free;
    has_free = 0; p_free = 0; p_conf = 0; p_dv = 0; p_sel = 0;
    for (int i = N_ENTRIES - 1; i >= 0; i--) begin
      if (!m_used[i]) begin has_free = 1; p_free = i; end
      if (m_fin(i)) begin p_dv = 1; p_sel = i; end
      if (m_used[i] && m_addr[i][7:0] == s.aa[7:0]) p_conf = 1;
    end
    if (m_hold) p_sel = m_hold_idx;
    p_ready = has_free && !p_conf;
  endtask

  task automatic model_edge(input stim_t s);
    int hit;
    bit nerr;
    if (s.rst) begin
      model_clear();
      return;
    end
    hit = -1;
    nerr = 0;
    for (int i = 0; i < N_ENTRIES; i++)
      if (m_used[i] && m_addr[i] == s.ra) hit = i;
    if (s.rv) begin
      if (hit < 0) nerr = 1;
      else if (m_fin(hit)) nerr = 1;
      else if (s.rd) begin
        if (!m_need[hit]) nerr = 1; else m_need[hit] = 0;
      end else begin
        if (m_cnt[hit] == 0) nerr = 1; else m_cnt[hit] = m_cnt[hit] - 1;
      end
    end
    m_hold = p_dv && !s.dr;
    m_hold_idx = p_sel;
    if (p_dv && s.dr) begin
      m_used[p_sel] = 0;
      m_nbusy--;
    end
    if (s.av && p_ready) begin
      m_used[p_free] = 1; m_addr[p_free] = s.aa; m_id[p_free] = int'(s.aid);
      m_getm[p_free] = s.ag; m_cnt[p_free] = int'(s.ac); m_need[p_free] = s.an;
      m_nbusy++;
    end
    m_err = nerr;
  endtask

  function automatic stim_t mk(input bit av, input logic [25:0] aa, input logic [3:0] aid,
                               input bit ag, input logic [3:0] ac, input bit an,
                               input bit rv, input logic [25:0] ra, input bit rd, input bit dr);
    stim_t s;
    s.rst = 0; s.av = av; s.aa = aa; s.aid = aid; s.ag = ag; s.ac = ac; s.an = an;
    s.rv = rv; s.ra = ra; s.rd = rd; s.dr = dr;
    return s;
  endfunction

  function automatic stim_t idle(input bit dr);
    return mk(0, 26'h55, 0, 0, 0, 0, 0, 26'h0, 0, dr);
  endfunction

  function automatic stim_t rsp(input logic [25:0] ra, input bit rd);
    return mk(0, 26'h55, 0, 0, 0, 0, 1, ra, rd, 0);
  endfunction

  // One clock: apply, sample/compare comb outputs, edge, sample/compare registered outputs.
  task automatic cycle(input stim_t s);
    rst                  = s.rst;
    bus.alloc_valid      = s.av;
    bus.alloc_line_addr  = s.aa;
    bus.alloc_req_id     = s.aid;
    bus.alloc_is_getm    = s.ag;
    bus.alloc_invack_cnt = s.ac;
    bus.alloc_need_data  = s.an;
    bus.rsp_valid        = s.rv;
    bus.rsp_line_addr    = s.ra;
    bus.rsp_is_data      = s.rd;
    bus.done_ready       = s.dr;
    #1;
    s_ready = bus.alloc_ready; s_conf = bus.alloc_conflict; s_idx = int'(bus.alloc_idx);
    s_dv = bus.done_valid; s_da = bus.done_line_addr; s_did = int'(bus.done_req_id);
    s_dg = bus.done_is_getm;
    model_predict(s);
    chk("m_alloc_ready", s_ready, p_ready);
    chk("m_alloc_conflict", s_conf, p_conf);
    chk("m_done_valid", s_dv, p_dv);
    if (p_ready) chk("m_alloc_idx", s_idx, p_free);
    if (p_dv) begin
      chk("m_done_line_addr", s_da, m_addr[p_sel]);
      chk("m_done_req_id", s_did, m_id[p_sel]);
      chk("m_done_is_getm", s_dg, m_getm[p_sel]);
    end
    @(posedge clk);
    model_edge(s);
    @(negedge clk);
    s_err = bus.rsp_err; s_busy = int'(bus.busy_count);
    chk("m_rsp_err", s_err, m_err);
    chk("m_busy_count", s_busy, m_nbusy);
  endtask

  vec_t tab [16];

  initial begin
    stim_t s;
    int hold_addr;

    // Directed vectors; comb expectations are pre-edge, busy/err are post-edge.
    tab[0]  = '{idle(0),                                   1,0,0,0,26'h0,  0,0,0};
    tab[1]  = '{mk(1,26'h100,1,1,2,0,0,0,0,0),             1,0,0,0,26'h0,  0,1,0};
    tab[2]  = '{mk(1,26'h200,2,0,0,0,0,0,0,0),             0,1,1,0,26'h0,  0,1,0};
    tab[3]  = '{mk(1,26'h101,3,0,1,1,0,0,0,0),             1,0,1,0,26'h0,  0,2,0};
    tab[4]  = '{rsp(26'h100,0),                            1,0,2,0,26'h0,  0,2,0};
    tab[5]  = '{rsp(26'h100,0),                            1,0,2,0,26'h0,  0,2,0};
    tab[6]  = '{idle(0),                                   1,0,2,1,26'h100,1,2,0};
    tab[7]  = '{rsp(26'h100,0),                            1,0,2,1,26'h100,1,2,1};
    tab[8]  = '{rsp(26'h3FF,0),                            1,0,2,1,26'h100,1,2,1};
    tab[9]  = '{idle(0),                                   1,0,2,1,26'h100,1,2,0};
    tab[10] = '{idle(1),                                   1,0,2,1,26'h100,1,1,0};
    tab[11] = '{rsp(26'h101,1),                            1,0,0,0,26'h0,  0,1,0};
    tab[12] = '{rsp(26'h101,1),                            1,0,0,0,26'h0,  0,1,1};
    tab[13] = '{rsp(26'h101,0),                            1,0,0,0,26'h0,  0,1,0};
    tab[14] = '{idle(1),                                   1,0,0,1,26'h101,0,0,0};
    tab[15] = '{idle(0),                                   1,0,0,0,26'h0,  0,0,0};

    // Clock/reset
    s = idle(0);
    s.rst = 1;
    rst = 1;
    bus.alloc_valid = 0; bus.alloc_line_addr = '0; bus.alloc_req_id = '0;
    bus.alloc_is_getm = 0; bus.alloc_invack_cnt = '0; bus.alloc_need_data = 0;
    bus.rsp_valid = 0; bus.rsp_line_addr = '0; bus.rsp_is_data = 0; bus.done_ready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_clear();
    chk("rst_busy_count", int'(bus.busy_count), 0);
    chk("rst_rsp_err", int'(bus.rsp_err), 0);

    for (int v = 0; v < 16; v++) begin
      cycle(tab[v].s);
      chk($sformatf("t%0d_alloc_ready", v), s_ready, tab[v].rdy);
      chk($sformatf("t%0d_alloc_conflict", v), s_conf, tab[v].conf);
      chk($sformatf("t%0d_alloc_idx", v), s_idx, tab[v].idx);
      chk($sformatf("t%0d_done_valid", v), s_dv, tab[v].dv);
      if (tab[v].dv) begin
        chk($sformatf("t%0d_done_line_addr", v), s_da, tab[v].da);
        chk($sformatf("t%0d_done_is_getm", v), s_dg, tab[v].dg);
      end
      chk($sformatf("t%0d_busy_count", v), s_busy, tab[v].busy);
      chk($sformatf("t%0d_rsp_err", v), s_err, tab[v].err);
    end

    // Zero-count alloc completes after one cycle; held completion stays put
    // even when a lower entry finishes during the hold.
    cycle(mk(1, 26'h30, 5, 0, 1, 0, 0, 0, 0, 0));
    cycle(mk(1, 26'h41, 6, 1, 0, 0, 0, 0, 0, 0));
    cycle(idle(0));
    chk("zl_done_valid", s_dv, 1);
    hold_addr = int'(s_da);
    chk("zl_done_line_addr", hold_addr, 32'h41);
    for (int k = 0; k < 5; k++) begin
      cycle(k == 0 ? rsp(26'h30, 0) : idle(0));
      chk("hold_done_line_addr", s_da, 26'h41);
      chk("hold_done_req_id", s_did, 6);
      chk("hold_done_is_getm", s_dg, 1);
    end
    cycle(idle(1));
    cycle(idle(1));
    chk("after_hold_done_line_addr", s_da, 26'h30);
    chk("after_hold_busy", s_busy, 0);

    // Fill all entries, then drain idx 2 while offering a new alloc.
    for (int k = 0; k < 4; k++) cycle(mk(1, 26'h10 + 26'(k), 4'(k), 0, 1, 0, 0, 0, 0, 0));
    chk("full_busy", s_busy, 4);
    cycle(rsp(26'h12, 0));
    chk("full_ready", s_ready, 0);
    cycle(mk(1, 26'h20, 9, 1, 1, 0, 0, 0, 0, 1));
    chk("freed_not_alloc_ready", s_ready, 0);
    cycle(mk(1, 26'h20, 9, 1, 1, 0, 0, 0, 0, 0));
    chk("refill_ready", s_ready, 1);
    chk("refill_idx", s_idx, 2);
    chk("refill_busy", s_busy, 4);

    // Drop to three waiting entries, then reset mid-flight.
    cycle(rsp(26'h13, 0));
    cycle(idle(1));
    chk("pre_rst_busy", s_busy, 3);
    s = idle(0);
    s.rst = 1;
    cycle(s);
    chk("post_rst_busy", s_busy, 0);
    cycle(rsp(26'h10, 0));
    chk("post_rst_done_valid", s_dv, 0);
    chk("post_rst_ready", s_ready, 1);
    chk("late_rsp_err", s_err, 1);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      int pick;
      s.rst = ($urandom_range(0, 199) == 0);
      s.av  = ($urandom_range(0, 2) != 0);
      s.aa  = (26'($urandom_range(0, 3)) << 8) | 26'($urandom_range(0, 5));
      s.aid = 4'($urandom_range(0, 15));
      s.ag  = 1'($urandom_range(0, 1));
      s.ac  = 4'($urandom_range(0, 3));
      s.an  = 1'($urandom_range(0, 1));
      s.rv  = ($urandom_range(0, 3) != 0);
      pick  = $urandom_range(0, N_ENTRIES - 1);
      if ($urandom_range(0, 3) != 0 && m_used[pick]) s.ra = m_addr[pick];
      else if ($urandom_range(0, 9) == 0) s.ra = 26'h3FF;
      else s.ra = (26'($urandom_range(0, 3)) << 8) | 26'($urandom_range(0, 5));
      s.rd  = ($urandom_range(0, 2) == 0);
      s.dr  = ($urandom_range(0, 2) != 0);
      cycle(s);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
